// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - debug master that streams a range of data-memory words
// Define DMEM_DUMP_CHECKSUM_EN to add a running checksum output over accepted words.
module dmem_dump_reader #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              dbg_sel,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
`ifdef DMEM_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              core_hold
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_PRESENT, S_DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [2:0]        LAT_LAST  = 3'(READ_LAT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [2:0]          wait_q, wait_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
`ifdef DMEM_DUMP_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          // Any count with the top bit set means "the whole memory".
          remaining_d = word_count[ADDR_W] ? MAX_COUNT : word_count;
          wait_d      = '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
          checksum_d  = '0;
`endif
          state_d     = (word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (wait_q == LAT_LAST) begin
          out_data_d = dbg_data;
          out_addr_d = cur_addr_q;
          state_d    = S_PRESENT;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_PRESENT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          remaining_d = remaining_q - CNT_ONE;
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          wait_d      = '0;
`ifdef DMEM_DUMP_CHECKSUM_EN
          checksum_d  = checksum_q + out_data_q;
`endif
          state_d     = (remaining_q == CNT_ONE) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    dbg_sel   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE:    busy = 1'b0;
      S_READ:    dbg_sel = 1'b1;
      S_PRESENT: begin
        dbg_sel   = 1'b1;
        out_valid = 1'b1;
      end
      S_DONE:    done = 1'b1;
      default:   busy = 1'b0;
    endcase
    dbg_addr  = dbg_sel ? cur_addr_q : '0;
    core_hold = dbg_sel;
    out_data  = out_data_q;
    out_addr  = out_addr_q;
`ifdef DMEM_DUMP_CHECKSUM_EN
    checksum  = checksum_q;
`endif
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb/tb_dmem_dump_reader.sv - directed bench for dmem_dump_reader with a 1-cycle memory model
module tb_dmem_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        dbg_sel;
  logic [9:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] out_data;
  logic [9:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        core_hold;
`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  logic [15:0] mem [0:1023];
  logic [15:0] got_data[$];
  logic [9:0]  got_addr[$];
  logic [15:0] stall_vals[$];
  int          done_cnt;
  int          valid_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  dmem_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done),
`ifdef DMEM_DUMP_CHECKSUM_EN
    .checksum(checksum),
`endif
    .core_hold(core_hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dbg_data <= mem[dbg_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] base, input logic [10:0] cnt);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Consumes the stream until the done pulse (left in the DONE cycle) or the cycle budget runs out.
  task automatic run_dump(input int max_cycles, input int stall_word, input int stall_len);
    int stall_left;
    stall_left = stall_len;
    got_data.delete();
    got_addr.delete();
    stall_vals.delete();
    done_cnt  = 0;
    valid_cnt = 0;
    for (int c = 0; c < max_cycles; c++) begin
      if (out_valid && got_data.size() == stall_word && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        stall_vals.push_back(out_data);
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_addr.push_back(out_addr);
      end
      if (done) begin
        done_cnt++;
        break;
      end
      tick();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    int bad;
    int nacc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; word_count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem[5] = 16'h1234;
    for (int i = 0; i < 3; i++) mem[i] = 16'h0100 + 16'(i);
    mem[10'h040] = 16'hFFFF; mem[10'h041] = 16'h0002; mem[10'h042] = 16'h0010;
    tick(); tick();
    rst = 1'b0;
    chk("reset_outs", {dbg_sel, dbg_addr, out_valid, busy, done, core_hold}, 0);
    chk("reset_data", {out_data, 6'd0, out_addr}, 0);

    // Single word, cycle-accurate
    do_start(10'd5, 11'd1);
    chk("sw_c1", {dbg_sel, core_hold, dbg_addr, out_valid, busy}, {1'b1, 1'b1, 10'd5, 1'b0, 1'b1});
    tick();
    chk("sw_c2", {dbg_sel, dbg_addr, out_valid}, {1'b1, 10'd5, 1'b0});
    tick();
    chk("sw_c3_valid", {out_valid, dbg_sel, done}, {1'b1, 1'b1, 1'b0});
    chk("sw_c3_data", {out_data, 6'd0, out_addr}, {16'h1234, 6'd0, 10'd5});
    tick();
    chk("sw_c4_done", {done, busy, out_valid, dbg_sel}, {1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    chk("sw_c5_idle", {busy, dbg_sel, done}, 0);

    // Backpressure on the second word
    do_start(10'd0, 11'd3);
    run_dump(100, 1, 4);
    chk("bp_count", got_data.size(), 3);
    for (int i = 0; i < got_data.size() && i < 3; i++)
      chk("bp_word", got_data[i], 16'h0100 + 16'(i));
    chk("bp_stall_len", stall_vals.size(), 4);
    for (int i = 0; i < stall_vals.size(); i++) chk("bp_stall_hold", stall_vals[i], 16'h0101);
    chk("bp_done", done_cnt, 1);
    tick();
    chk("bp_idle", {busy, done}, 0);

    // Address wrap-around
    do_start(10'h3FE, 11'd4);
    run_dump(100, -1, 0);
    chk("wrap_count", got_addr.size(), 4);
    for (int i = 0; i < got_addr.size() && i < 4; i++) begin
      logic [9:0] ea;
      ea = 10'h3FE + 10'(i);
      chk("wrap_addr", got_addr[i], ea);
      chk("wrap_data", got_data[i], mem[ea]);
    end
    tick();

    // Zero count
    do_start(10'h010, 11'd0);
    chk("zero_c1", {done, busy, out_valid, dbg_sel}, {1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    chk("zero_c2", {done, busy, out_valid}, 0);

    // Clamp to a full-memory dump
    do_start(10'h123, 11'h7FF);
    run_dump(4000, -1, 0);
    chk("clamp_count", got_addr.size(), 1024);
    chk("clamp_first", got_addr.size() > 0 ? got_addr[0] : 10'h0, 10'h123);
    chk("clamp_last", got_addr.size() > 0 ? got_addr[got_addr.size()-1] : 10'h0, 10'h122);
    bad = 0;
    for (int i = 0; i < got_addr.size(); i++)
      if (got_addr[i] !== 10'(10'h123 + 10'(i)) || got_data[i] !== mem[10'(10'h123 + 10'(i))]) bad++;
    chk("clamp_stream_bad", bad, 0);
    chk("clamp_done", done_cnt, 1);
    tick();

    // Abort while word 2 of 5 is presented, with out_ready also high
    do_start(10'h010, 11'd5);
    nacc = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (out_valid && nacc == 1) break;
      if (out_valid) nacc++;
      tick();
    end
    chk("abort_at_word2", {out_valid, out_addr}, {1'b1, 10'h011});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {busy, dbg_sel, out_valid, done, core_hold}, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) bad++;
    end
    chk("abort_no_done", bad, 0);

    // Reset during READ
    do_start(10'h080, 11'd3);
    chk("rst_in_read", {dbg_sel, out_valid}, {1'b1, 1'b0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outs", {dbg_sel, dbg_addr, out_valid, busy, done, core_hold}, 0);
    chk("rst_data", {out_data, 6'd0, out_addr}, 0);

    // Start while busy is ignored
    do_start(10'h050, 11'd2);
    base_addr = 10'h200; word_count = 11'd5; start = 1'b1;
    tick();
    start = 1'b0;
    run_dump(100, -1, 0);
    chk("busy_start_count", got_addr.size(), 2);
    chk("busy_start_a0", got_addr.size() > 0 ? got_addr[0] : 10'h0, 10'h050);
    chk("busy_start_a1", got_addr.size() > 1 ? got_addr[1] : 10'h0, 10'h051);
    chk("busy_start_done", done_cnt, 1);
    tick();

`ifdef DMEM_DUMP_CHECKSUM_EN
    do_start(10'h040, 11'd3);
    run_dump(100, -1, 0);
    chk("csum_at_done", checksum, 16'h0011);
    tick(); tick();
    chk("csum_hold", checksum, 16'h0011);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
